// File: rtl/bcd_add_if.sv
// Request/acknowledge bus between bcd_add_controller and bcd_add_datapath,
// plus the operand switches and the display/busy outputs.
interface bcd_add_if #(
  parameter int DIGITS = 2
);
  logic [4*DIGITS-1:0] sw;
  logic                bcd_init;
  logic                bcd_init_ack;
  logic                bcd_load_a;
  logic                bcd_load_a_ack;
  logic                bcd_load_b;
  logic                bcd_load_b_ack;
  logic                bcd_display_a;
  logic                bcd_display_a_ack;
  logic                bcd_display_b;
  logic                bcd_display_b_ack;
  logic                bcd_add;
  logic                bcd_add_ack;
  logic                bcd_display_result_ls;
  logic                bcd_display_result_ls_ack;
  logic                bcd_display_result_ms;
  logic                bcd_display_result_ms_ack;
  logic [4*DIGITS-1:0] display;
  logic                busy;

  // 4-phase handshake: the master raises a request and holds it, the slave raises
  // the matching ack and holds it while the request stays high; the master drops
  // the request, the slave drops the ack, and only then is a new request accepted.
  modport master (
    output sw, bcd_init, bcd_load_a, bcd_load_b, bcd_display_a, bcd_display_b,
           bcd_add, bcd_display_result_ls, bcd_display_result_ms,
    input  bcd_init_ack, bcd_load_a_ack, bcd_load_b_ack, bcd_display_a_ack,
           bcd_display_b_ack, bcd_add_ack, bcd_display_result_ls_ack,
           bcd_display_result_ms_ack, display, busy
  );

  modport slave (
    input  sw, bcd_init, bcd_load_a, bcd_load_b, bcd_display_a, bcd_display_b,
           bcd_add, bcd_display_result_ls, bcd_display_result_ms,
    output bcd_init_ack, bcd_load_a_ack, bcd_load_b_ack, bcd_display_a_ack,
           bcd_display_b_ack, bcd_add_ack, bcd_display_result_ls_ack,
           bcd_display_result_ms_ack, display, busy
  );
endinterface

// File: rtl/bcd_add_datapath.sv
// Responder for the BCD adder controller: holds operands A/B, performs a digit-serial
// BCD add into R and drives the display register, answering each request with its ack.
module bcd_add_datapath #(
  parameter int DIGITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  bcd_add_if.slave              bus,
  output logic [1:0]            dbg_state_o,
  output logic [4*DIGITS+3:0]   dbg_r_o
);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADD = 2'd1, ST_ACK = 2'd2} state_e;
  // Index order is also the service priority, lowest index wins.
  typedef enum logic [2:0] {
    OP_INIT = 3'd0, OP_LOAD_A = 3'd1, OP_LOAD_B = 3'd2, OP_ADD = 3'd3,
    OP_DISP_A = 3'd4, OP_DISP_B = 3'd5, OP_LS = 3'd6, OP_MS = 3'd7
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
  logic [4*DIGITS+3:0] r_q, r_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [7:0]          ack_q, ack_d;
  logic [7:0]          req;
  logic [2:0]          win;
  logic [3:0]          a_dig, b_dig;
  logic [4:0]          sum;

  function automatic logic [4*DIGITS-1:0] sat(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] o;
    o = v;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) o[4*i +: 4] = 4'd9;
    return o;
  endfunction

  assign req = {bus.bcd_display_result_ms, bus.bcd_display_result_ls, bus.bcd_display_b,
                bus.bcd_display_a, bus.bcd_add, bus.bcd_load_b, bus.bcd_load_a,
                bus.bcd_init};

  always_comb begin
    win = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (req[i]) win = 3'(i);
  end

  assign a_dig = a_q[4*int'(idx_q) +: 4];
  assign b_dig = b_q[4*int'(idx_q) +: 4];
  assign sum   = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    disp_d  = disp_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    ack_d   = ack_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          op_d = op_e'(win);
          if (op_e'(win) == OP_ADD) begin
            idx_d   = '0;
            carry_d = 1'b0;
            state_d = ST_ADD;
          end else begin
            ack_d   = 8'b1 << win;
            state_d = ST_ACK;
            case (op_e'(win))
              OP_INIT: begin
                a_d    = '0;
                b_d    = '0;
                r_d    = '0;
                disp_d = '0;
              end
              OP_LOAD_A: a_d    = sat(bus.sw);
              OP_LOAD_B: b_d    = sat(bus.sw);
              OP_DISP_A: disp_d = a_q;
              OP_DISP_B: disp_d = b_q;
              OP_LS:     disp_d = r_q[4*DIGITS-1:0];
              OP_MS: begin
                disp_d      = '0;
                disp_d[3:0] = r_q[4*DIGITS +: 4];
              end
              default: ;
            endcase
          end
        end
      end
      ST_ADD: begin
        // One digit per cycle; the add runs to completion even if the request drops.
        if (sum > 5'd9) begin
          r_d[4*int'(idx_q) +: 4] = 4'(sum - 5'd10);
          carry_d = 1'b1;
        end else begin
          r_d[4*int'(idx_q) +: 4] = sum[3:0];
          carry_d = 1'b0;
        end
        if (idx_q == IDXW'(DIGITS - 1)) begin
          r_d[4*DIGITS +: 4] = {3'b0, carry_d};
          ack_d   = 8'b1 << OP_ADD;
          state_d = ST_ACK;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_ACK: begin
        if (!req[op_q]) begin
          ack_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_INIT;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      disp_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      disp_q  <= disp_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.bcd_init_ack              = ack_q[OP_INIT];
  assign bus.bcd_load_a_ack            = ack_q[OP_LOAD_A];
  assign bus.bcd_load_b_ack            = ack_q[OP_LOAD_B];
  assign bus.bcd_add_ack               = ack_q[OP_ADD];
  assign bus.bcd_display_a_ack         = ack_q[OP_DISP_A];
  assign bus.bcd_display_b_ack         = ack_q[OP_DISP_B];
  assign bus.bcd_display_result_ls_ack = ack_q[OP_LS];
  assign bus.bcd_display_result_ms_ack = ack_q[OP_MS];
  assign bus.display                   = disp_q;
  assign bus.busy                      = (state_q != ST_IDLE);
  assign dbg_state_o                   = state_q;
  assign dbg_r_o                       = r_q;
endmodule

// File: tb/tb_bcd_add_datapath.sv
// Directed bench for bcd_add_datapath: handshakes, BCD add, saturation, priority
// and asynchronous reset during an add.
module tb_bcd_add_datapath;
  localparam int DIGITS = 2;
  localparam int OP_INIT = 0, OP_LOAD_A = 1, OP_LOAD_B = 2, OP_ADD = 3;
  localparam int OP_DISP_A = 4, OP_DISP_B = 5, OP_LS = 6, OP_MS = 7;

  logic                  clk;
  logic                  rst_n;
  logic [7:0]            req_v;
  logic [7:0]            ack_v;
  logic [1:0]            dbg_state;
  logic [4*DIGITS+3:0]   dbg_r;
  int                    vectors;
  int                    miscompares;

  bcd_add_if #(.DIGITS(DIGITS)) bus ();

  bcd_add_datapath #(.DIGITS(DIGITS)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state),
    .dbg_r_o    (dbg_r)
  );

  assign bus.bcd_init              = req_v[OP_INIT];
  assign bus.bcd_load_a            = req_v[OP_LOAD_A];
  assign bus.bcd_load_b            = req_v[OP_LOAD_B];
  assign bus.bcd_add               = req_v[OP_ADD];
  assign bus.bcd_display_a         = req_v[OP_DISP_A];
  assign bus.bcd_display_b         = req_v[OP_DISP_B];
  assign bus.bcd_display_result_ls = req_v[OP_LS];
  assign bus.bcd_display_result_ms = req_v[OP_MS];
  assign ack_v = {bus.bcd_display_result_ms_ack, bus.bcd_display_result_ls_ack,
                  bus.bcd_display_b_ack, bus.bcd_display_a_ack, bus.bcd_add_ack,
                  bus.bcd_load_b_ack, bus.bcd_load_a_ack, bus.bcd_init_ack};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full 4-phase handshake; lat = edges from request sampled to ack visible.
  task automatic handshake(input int op, input int lat, input string tag);
    logic [7:0] e;
    e = 8'b1 << op;
    req_v[op] = 1'b1;
    for (int k = 1; k < lat; k++) begin
      tick;
      check({tag, " ack early"}, 32'(ack_v), 32'h0);
    end
    tick;
    check({tag, " ack"}, 32'(ack_v), 32'(e));
    check({tag, " busy"}, 32'(bus.busy), 32'h1);
    req_v[op] = 1'b0;
    tick;
    check({tag, " ack drop"}, 32'(ack_v), 32'h0);
    check({tag, " idle"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_v       = '0;
    bus.sw      = '0;

    // 1. reset
    tick;
    tick;
    check("rst display", 32'(bus.display), 32'h0);
    check("rst acks", 32'(ack_v), 32'h0);
    check("rst busy", 32'(bus.busy), 32'h0);
    check("rst state", 32'(dbg_state), 32'h0);
    rst_n = 1'b1;
    tick;
    tick;
    tick;
    check("post-rst busy", 32'(bus.busy), 32'h0);
    check("post-rst acks", 32'(ack_v), 32'h0);

    // 2. 47 + 38 = 85
    bus.sw = 8'h47;
    handshake(OP_LOAD_A, 1, "load_a 47");
    bus.sw = 8'h38;
    handshake(OP_LOAD_B, 1, "load_b 38");
    handshake(OP_ADD, 1 + DIGITS, "add 47+38");
    check("r 47+38", 32'(dbg_r), 32'h085);
    check("display kept", 32'(bus.display), 32'h0);
    handshake(OP_LS, 1, "ls 85");
    check("display ls 85", 32'(bus.display), 32'h85);
    handshake(OP_MS, 1, "ms 85");
    check("display ms 85", 32'(bus.display), 32'h00);

    // 3. 99 + 99 = 198
    bus.sw = 8'h99;
    handshake(OP_LOAD_A, 1, "load_a 99");
    handshake(OP_LOAD_B, 1, "load_b 99");
    handshake(OP_ADD, 1 + DIGITS, "add 99+99");
    check("r 99+99", 32'(dbg_r), 32'h198);
    handshake(OP_LS, 1, "ls 198");
    check("display ls 198", 32'(bus.display), 32'h98);
    handshake(OP_MS, 1, "ms 198");
    check("display ms 198", 32'(bus.display), 32'h01);

    // 4. saturation on load
    bus.sw = 8'hAF;
    handshake(OP_LOAD_A, 1, "load_a AF");
    check("display after load", 32'(bus.display), 32'h01);
    handshake(OP_DISP_A, 1, "disp_a sat");
    check("display sat A", 32'(bus.display), 32'h99);
    bus.sw = 8'h5C;
    handshake(OP_LOAD_B, 1, "load_b 5C");
    handshake(OP_DISP_B, 1, "disp_b sat");
    check("display sat B", 32'(bus.display), 32'h59);

    // 5. priority and held ack
    bus.sw = 8'h12;
    req_v[OP_LOAD_A] = 1'b1;
    req_v[OP_LOAD_B] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("prio ack held", 32'(ack_v), 32'h02);
    end
    req_v[OP_LOAD_A] = 1'b0;
    req_v[OP_LOAD_B] = 1'b0;
    tick;
    check("prio ack drop", 32'(ack_v), 32'h0);
    handshake(OP_DISP_B, 1, "disp_b kept");
    check("B unchanged", 32'(bus.display), 32'h59);
    handshake(OP_DISP_A, 1, "disp_a 12");
    check("A loaded", 32'(bus.display), 32'h12);

    // ADD request dropped mid-add: 12 + 59 = 71
    req_v[OP_ADD] = 1'b1;
    tick;
    req_v[OP_ADD] = 1'b0;
    check("drop add busy", 32'(bus.busy), 32'h1);
    tick;
    check("drop add early", 32'(ack_v), 32'h0);
    tick;
    check("drop add ack", 32'(ack_v), 32'h08);
    tick;
    check("drop add ack drop", 32'(ack_v), 32'h0);
    check("drop add idle", 32'(bus.busy), 32'h0);
    check("r 12+59", 32'(dbg_r), 32'h071);
    handshake(OP_LS, 1, "ls 71");
    check("display ls 71", 32'(bus.display), 32'h71);

    // 6. reset during add
    req_v[OP_ADD] = 1'b1;
    tick;
    check("add accepted", 32'(dbg_state), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort acks", 32'(ack_v), 32'h0);
    check("abort state", 32'(dbg_state), 32'h0);
    check("abort r", 32'(dbg_r), 32'h0);
    check("abort display", 32'(bus.display), 32'h0);
    tick;
    req_v = '0;
    rst_n = 1'b1;
    tick;
    tick;
    check("after abort acks", 32'(ack_v), 32'h0);
    check("after abort busy", 32'(bus.busy), 32'h0);
    handshake(OP_INIT, 1, "init");
    check("init display", 32'(bus.display), 32'h0);
    check("init r", 32'(dbg_r), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
